// File: rtl/int_gen_burst_if.sv
// Control/status bundle between the parameter/UI logic (master) and the
// interrupter generator (slave).
interface int_gen_burst_if #(
  parameter int PAR_W = 8
) ();
  logic             en;
  logic [1:0]       mode;
  logic [PAR_W-1:0] freq_par;
  logic [PAR_W-1:0] pw_par;
  logic [PAR_W-1:0] burst_len;
  logic [PAR_W-1:0] burst_gap;
  logic             trig;
  logic             out;
  logic             busy;
  logic             period_strobe;

  modport master (
    output en, mode, freq_par, pw_par, burst_len, burst_gap, trig,
    input  out, busy, period_strobe
  );

  modport slave (
    input  en, mode, freq_par, pw_par, burst_len, burst_gap, trig,
    output out, busy, period_strobe
  );
endinterface

// File: rtl/int_gen_burst.sv
// DRSSTC interrupter generator: continuous, burst and one-shot gate timing.
// Optional hard duty ceiling enabled with macro MAX_DUTY_EN.
module int_gen_burst #(
  parameter int PAR_W       = 8,
  parameter int PER_BASE_SH = 19,
  parameter int PER_STEP_SH = 14,
  parameter int PW_SH       = 9,
  parameter int DUTY_SH     = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  int_gen_burst_if.slave bus
);

  localparam longint MAX_PER = (longint'(1) << PER_BASE_SH)
                             + (((longint'(1) << PAR_W) - longint'(1)) << PER_STEP_SH);
  localparam int CNT_W = $clog2(MAX_PER + longint'(1));
  localparam int PW_W  = PAR_W + PW_SH;
  localparam int CW    = (CNT_W > PW_W) ? CNT_W : PW_W;

`ifdef MAX_DUTY_EN
  localparam bit DUTY_EN = 1'b1;
`else
  localparam bit DUTY_EN = 1'b0;
`endif

  localparam logic [1:0] MODE_BURST   = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [CW-1:0] min_cw(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] elapsed_r, elapsed_s;
  logic [PAR_W-1:0] gap_cnt_r, gap_cnt_s;
  logic [PAR_W-1:0] pulse_cnt_r, pulse_cnt_s;
  logic [1:0]       mode_r;
  logic [CNT_W-1:0] per_r;
  logic [CNT_W-1:0] pw_r;
  logic [PAR_W-1:0] blen_r;
  logic [PAR_W-1:0] bgap_r;
  logic             out_r, busy_r, strobe_r;

  logic [CNT_W-1:0] per_s;
  logic [CW-1:0]    per_m1_s, pw_raw_s, duty_cap_s, pw_cap_s;
  logic [CNT_W-1:0] pw_eff_s;
  logic [PAR_W-1:0] blen_eff_s;
  logic [PAR_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] pw_nx_s;
  logic             last_s, start_s, out_s, busy_s;

  // period/pulse arithmetic from the live parameters, sampled only at period start
  always_comb begin
    per_s      = CNT_W'(longint'(1) << PER_BASE_SH) + (CNT_W'(bus.freq_par) << PER_STEP_SH);
    per_m1_s   = CW'(per_s) - CW'(1);
    pw_raw_s   = CW'(bus.pw_par) << PW_SH;
    duty_cap_s = CW'(per_s) >> DUTY_SH;
    if (DUTY_EN) begin
      pw_cap_s = min_cw(per_m1_s, duty_cap_s);
    end else begin
      pw_cap_s = per_m1_s;
    end
    pw_eff_s   = CNT_W'(min_cw(pw_raw_s, pw_cap_s));
    blen_eff_s = (bus.burst_len == {PAR_W{1'b0}}) ? PAR_W'(1) : bus.burst_len;
  end

  assign last_s    = (elapsed_r == (per_r - CNT_W'(1)));
  assign cnt_inc_s = pulse_cnt_r + PAR_W'(1);

  // next-state, counter and period-start decode
  always_comb begin
    state_s     = state_r;
    elapsed_s   = elapsed_r;
    gap_cnt_s   = gap_cnt_r;
    pulse_cnt_s = pulse_cnt_r;
    start_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.en && ((bus.mode != MODE_ONESHOT) || bus.trig)) begin
          start_s     = 1'b1;
          state_s     = ST_RUN;
          elapsed_s   = {CNT_W{1'b0}};
          gap_cnt_s   = {PAR_W{1'b0}};
          pulse_cnt_s = {PAR_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!bus.en) begin
          state_s     = ST_IDLE;
          elapsed_s   = {CNT_W{1'b0}};
          gap_cnt_s   = {PAR_W{1'b0}};
          pulse_cnt_s = {PAR_W{1'b0}};
        end else if (last_s) begin
          case (mode_r)
            MODE_BURST: begin
              if (cnt_inc_s < blen_r) begin
                start_s     = 1'b1;
                elapsed_s   = {CNT_W{1'b0}};
                pulse_cnt_s = cnt_inc_s;
              end else if (bgap_r != {PAR_W{1'b0}}) begin
                state_s     = ST_GAP;
                elapsed_s   = {CNT_W{1'b0}};
                gap_cnt_s   = {PAR_W{1'b0}};
                pulse_cnt_s = {PAR_W{1'b0}};
              end else begin
                start_s     = 1'b1;
                elapsed_s   = {CNT_W{1'b0}};
                pulse_cnt_s = {PAR_W{1'b0}};
              end
            end
            MODE_ONESHOT: begin
              state_s   = ST_IDLE;
              elapsed_s = {CNT_W{1'b0}};
            end
            default: begin
              start_s   = 1'b1;
              elapsed_s = {CNT_W{1'b0}};
            end
          endcase
        end else begin
          elapsed_s = elapsed_r + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (!bus.en) begin
          state_s     = ST_IDLE;
          elapsed_s   = {CNT_W{1'b0}};
          gap_cnt_s   = {PAR_W{1'b0}};
          pulse_cnt_s = {PAR_W{1'b0}};
        end else if (last_s) begin
          if (gap_cnt_r == (bgap_r - PAR_W'(1))) begin
            start_s     = 1'b1;
            state_s     = ST_RUN;
            elapsed_s   = {CNT_W{1'b0}};
            gap_cnt_s   = {PAR_W{1'b0}};
            pulse_cnt_s = {PAR_W{1'b0}};
          end else begin
            gap_cnt_s = gap_cnt_r + PAR_W'(1);
            elapsed_s = {CNT_W{1'b0}};
          end
        end else begin
          elapsed_s = elapsed_r + CNT_W'(1);
        end
      end
      default: begin
        state_s     = ST_IDLE;
        elapsed_s   = {CNT_W{1'b0}};
        gap_cnt_s   = {PAR_W{1'b0}};
        pulse_cnt_s = {PAR_W{1'b0}};
      end
    endcase

    // outputs are decoded from the next state so they register in step with it
    pw_nx_s = start_s ? pw_eff_s : pw_r;
    out_s   = (state_s == ST_RUN) && (elapsed_s < pw_nx_s);
    busy_s  = (state_s != ST_IDLE);
  end

  // state, counters, parameter latches and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      elapsed_r   <= {CNT_W{1'b0}};
      gap_cnt_r   <= {PAR_W{1'b0}};
      pulse_cnt_r <= {PAR_W{1'b0}};
      mode_r      <= 2'd0;
      per_r       <= {CNT_W{1'b0}};
      pw_r        <= {CNT_W{1'b0}};
      blen_r      <= {PAR_W{1'b0}};
      bgap_r      <= {PAR_W{1'b0}};
      out_r       <= 1'b0;
      busy_r      <= 1'b0;
      strobe_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      elapsed_r   <= elapsed_s;
      gap_cnt_r   <= gap_cnt_s;
      pulse_cnt_r <= pulse_cnt_s;
      out_r       <= out_s;
      busy_r      <= busy_s;
      strobe_r    <= start_s;
      if (start_s) begin
        mode_r <= bus.mode;
        per_r  <= per_s;
        pw_r   <= pw_eff_s;
        blen_r <= blen_eff_s;
        bgap_r <= bus.burst_gap;
      end
    end
  end

  assign bus.out           = out_r;
  assign bus.busy          = busy_r;
  assign bus.period_strobe = strobe_r;

endmodule

// File: tb/tb_int_gen_burst.sv
// Directed bench for int_gen_burst with small shifts: per = 16 + 4*freq_par, pw = 2*pw_par.
module tb_int_gen_burst;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   clamp_hi;

  always #5 clk = ~clk;

  int_gen_burst_if #(.PAR_W(8)) bus ();

  int_gen_burst #(
    .PAR_W(8), .PER_BASE_SH(4), .PER_STEP_SH(2), .PW_SH(1), .DUTY_SH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int cyc, input logic eo, input logic eb, input logic es);
    chk({tag, ".out"}, cyc, bus.out, eo);
    chk({tag, ".busy"}, cyc, bus.busy, eb);
    chk({tag, ".strobe"}, cyc, bus.period_strobe, es);
  endtask

  task automatic setup(input logic [1:0] m, input logic [7:0] f, input logic [7:0] p,
                       input logic [7:0] bl, input logic [7:0] bg);
    bus.mode      = m;
    bus.freq_par  = f;
    bus.pw_par    = p;
    bus.burst_len = bl;
    bus.burst_gap = bg;
  endtask

  task automatic stop(input string tag);
    bus.en   = 1'b0;
    bus.trig = 1'b0;
    tick();
    chk3(tag, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.trig = 1'b0;
    setup(2'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    tick();
    chk3("reset", 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk3("idle", 0, 1'b0, 1'b0, 1'b0);

    // continuous: 6 high / 14 low, strobe every 20
    setup(2'd0, 8'd1, 8'd3, 8'd0, 8'd0);
    bus.en = 1'b1;
    tick();
    for (int c = 0; c < 60; c++) begin
      chk3("cont", c, (c % 20) < 6, 1'b1, (c % 20) == 0);
      tick();
    end
    stop("cont_stop");

    // clamp: pw exceeds period
`ifdef MAX_DUTY_EN
    clamp_hi = 5;
`else
    clamp_hi = 19;
`endif
    setup(2'd0, 8'd1, 8'd255, 8'd0, 8'd0);
    bus.en = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      chk3("clamp", c, (c % 20) < clamp_hi, 1'b1, (c % 20) == 0);
      tick();
    end
    stop("clamp_stop");

    // burst: 3 pulses, 2-period gap, next burst at 100
    setup(2'd1, 8'd1, 8'd3, 8'd3, 8'd2);
    bus.en = 1'b1;
    tick();
    for (int c = 0; c < 120; c++) begin
      chk3("burst", c, ((c < 60) || (c >= 100)) && ((c % 20) < 6), 1'b1,
           ((c < 60) || (c >= 100)) && ((c % 20) == 0));
      tick();
    end
    stop("burst_stop");

    // one-shot with ignored retrigger at cycle 5
    setup(2'd2, 8'd1, 8'd3, 8'd0, 8'd0);
    bus.en   = 1'b1;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    for (int c = 0; c < 25; c++) begin
      chk3("shot", c, c < 6, c < 20, c == 0);
      bus.trig = (c == 5);
      tick();
    end
    // trig held: second shot after exactly one idle cycle
    bus.trig = 1'b1;
    tick();
    for (int c = 0; c < 25; c++) begin
      chk3("retrig", c, (c < 6) || (c >= 21), c != 20, (c == 0) || (c == 21));
      tick();
    end
    stop("shot_stop");

    // kill on enable drop mid-pulse
    setup(2'd0, 8'd1, 8'd3, 8'd0, 8'd0);
    bus.en = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk3("kill_pre", 3, 1'b1, 1'b1, 1'b0);
    bus.en = 1'b0;
    tick();
    chk3("kill", 4, 1'b0, 1'b0, 1'b0);

    // freq change mid-period takes effect only on the next period
    bus.en = 1'b1;
    tick();
    for (int c = 0; c < 53; c++) begin
      chk3("latch", c, (c < 6) || ((c >= 20) && (c < 26)) || (c >= 52), 1'b1,
           (c == 0) || (c == 20) || (c == 52));
      if (c == 3) bus.freq_par = 8'd4;
      tick();
    end
    stop("latch_stop");

    // async reset mid-pulse
    setup(2'd0, 8'd1, 8'd3, 8'd0, 8'd0);
    bus.en = 1'b1;
    tick();
    tick();
    chk3("arst_pre", 1, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk3("arst", 1, 1'b0, 1'b0, 1'b0);
    bus.en = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk3("arst_post", 0, 1'b0, 1'b0, 1'b0);

    // pw_par = 0: no gate, strobes continue
    setup(2'd0, 8'd1, 8'd0, 8'd0, 8'd0);
    bus.en = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      chk3("pw0", c, 1'b0, 1'b1, (c % 20) == 0);
      tick();
    end
    stop("pw0_stop");

    // burst_len = 0 acts as 1, 1-period gap
    setup(2'd1, 8'd1, 8'd3, 8'd0, 8'd1);
    bus.en = 1'b1;
    tick();
    for (int c = 0; c < 60; c++) begin
      chk3("blen0", c, ((c < 20) || (c >= 40)) && ((c % 20) < 6), 1'b1,
           (c == 0) || (c == 40));
      tick();
    end
    stop("blen0_stop");

    // mode 3 acts as continuous
    setup(2'd3, 8'd1, 8'd3, 8'd0, 8'd0);
    bus.en = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      chk3("mode3", c, (c % 20) < 6, 1'b1, (c % 20) == 0);
      tick();
    end
    stop("mode3_stop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
